// File: rtl/nibble_serial_alu_ctrl_pkg.sv
// rtl/nibble_serial_alu_ctrl_pkg.sv - shared encodings and helpers for the nibble-serial ALU sequencer
package nibble_serial_alu_ctrl_pkg;

  localparam int NIBBLE_W = 4;

  // Operand select encodings understood by the 4-bit arithmetic unit
  localparam logic [1:0] AU_S_B    = 2'b00;
  localparam logic [1:0] AU_S_NB   = 2'b01;
  localparam logic [1:0] AU_S_ZERO = 2'b10;
  localparam logic [1:0] AU_S_ONES = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  // Sign bit of the operand the unit actually adds, given the select and B's sign bit
  function automatic logic sel_d3(input logic [1:0] s, input logic b3);
    case (s)
      AU_S_B:    sel_d3 = b3;
      AU_S_NB:   sel_d3 = ~b3;
      AU_S_ZERO: sel_d3 = 1'b0;
      default:   sel_d3 = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/nibble_serial_alu_ctrl_shreg.sv
// rtl/nibble_serial_alu_ctrl_shreg.sv - nibble_shreg: loadable right shift-by-4 register with serial nibble input at the top
module nibble_shreg
  import nibble_serial_alu_ctrl_pkg::*;
#(
  parameter int W = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                load,
  input  logic                shift,
  input  logic [W-1:0]        load_data,
  input  logic [NIBBLE_W-1:0] ser_in,
  output logic [W-1:0]        q
);

  // Parallel load wins over shift; a shift drops the LSB nibble and inserts ser_in at the top
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (load) begin
      q <= load_data;
    end else if (shift) begin
      q <= {ser_in, q[W-1:NIBBLE_W]};
    end
  end

endmodule

// File: rtl/nibble_serial_alu_ctrl.sv
// rtl/nibble_serial_alu_ctrl.sv - wide add/sub sequencer driving a 4-bit arithmetic unit one nibble per clock (NSALU_FLAGS_EN enables zero/ovf flags)
module nibble_serial_alu_ctrl
  import nibble_serial_alu_ctrl_pkg::*;
#(
  parameter  int NIBBLES = 4,
  localparam int W       = NIBBLE_W * NIBBLES
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start_valid,
  output logic                start_ready,
  input  logic [W-1:0]        a_in,
  input  logic [W-1:0]        b_in,
  input  logic [1:0]          s_in,
  input  logic                cin_in,
  output logic [NIBBLE_W-1:0] au_a,
  output logic [NIBBLE_W-1:0] au_b,
  output logic [1:0]          au_s,
  output logic                au_cin,
  input  logic [NIBBLE_W-1:0] au_r,
  input  logic                au_cout,
  output logic                res_valid,
  input  logic                res_ready,
  output logic [W-1:0]        result,
  output logic                cout,
  output logic                zero,
  output logic                ovf
);

  localparam int CNT_W = (NIBBLES > 2) ? $clog2(NIBBLES) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NIBBLES - 1);

  state_t          state;
  logic [1:0]      s_reg;
  logic            carry_reg;
  logic [CNT_W-1:0] cnt;
  logic [W-1:0]    a_q;
  logic [W-1:0]    b_q;
  logic [W-1:0]    res_q;

  logic accept;
  logic running;
  logic last_nib;

  assign accept   = (state == ST_IDLE) && start_valid;
  assign running  = (state == ST_RUN);
  assign last_nib = running && (cnt == LAST_CNT);

  assign start_ready = (state == ST_IDLE);
  assign res_valid   = (state == ST_DONE);
  assign result      = res_q;

  // The unit only sees live operands while running; it is fed zeros otherwise
  assign au_a   = running ? a_q[NIBBLE_W-1:0] : '0;
  assign au_b   = running ? b_q[NIBBLE_W-1:0] : '0;
  assign au_s   = running ? s_reg : 2'b00;
  assign au_cin = running ? carry_reg : 1'b0;

  nibble_shreg #(.W(W)) u_a_sh (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (accept),
    .shift     (running),
    .load_data (a_in),
    .ser_in    ('0),
    .q         (a_q)
  );

  nibble_shreg #(.W(W)) u_b_sh (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (accept),
    .shift     (running),
    .load_data (b_in),
    .ser_in    ('0),
    .q         (b_q)
  );

  // Result nibbles arrive LSB first, so after NIBBLES shifts the first one sits at the bottom
  nibble_shreg #(.W(W)) u_res_sh (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (1'b0),
    .shift     (running),
    .load_data ('0),
    .ser_in    (au_r),
    .q         (res_q)
  );

  // Sequencer: accept operands, step one nibble per clock with a registered carry, hold result until taken
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      s_reg     <= 2'b00;
      carry_reg <= 1'b0;
      cnt       <= '0;
      cout      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start_valid) begin
            s_reg     <= s_in;
            carry_reg <= cin_in;
            cnt       <= '0;
            state     <= ST_RUN;
          end
        end
        ST_RUN: begin
          carry_reg <= au_cout;
          cnt       <= cnt + 1'b1;
          if (cnt == LAST_CNT) begin
            cout  <= au_cout;
            state <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (res_ready) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef NSALU_FLAGS_EN
  logic [W-1:0] final_res;
  logic         d3;

  assign final_res = {au_r, res_q[W-1:NIBBLE_W]};
  assign d3        = sel_d3(s_reg, b_q[NIBBLE_W-1]);

  // Flags are captured alongside the last nibble so they line up with the completed result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zero <= 1'b0;
      ovf  <= 1'b0;
    end else if (last_nib) begin
      zero <= (final_res == '0);
      ovf  <= (a_q[NIBBLE_W-1] == d3) && (au_r[NIBBLE_W-1] != a_q[NIBBLE_W-1]);
    end
  end
`else
  assign zero = 1'b0;
  assign ovf  = 1'b0;
`endif

endmodule

// File: tb/tb_nibble_serial_alu_ctrl.sv
// tb/tb_nibble_serial_alu_ctrl.sv - directed table-driven bench for nibble_serial_alu_ctrl with a behavioural 4-bit unit
module tb_nibble_serial_alu_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_valid;
  logic        start_ready;
  logic [15:0] a_in, b_in;
  logic [1:0]  s_in;
  logic        cin_in;
  logic [3:0]  au_a, au_b;
  logic [1:0]  au_s;
  logic        au_cin;
  logic [3:0]  au_r;
  logic        au_cout;
  logic        res_valid;
  logic        res_ready;
  logic [15:0] result;
  logic        cout;
  logic        zero;
  logic        ovf;

  int checks = 0;
  int errors = 0;

`ifdef NSALU_FLAGS_EN
  localparam logic FLAGS_ON = 1'b1;
`else
  localparam logic FLAGS_ON = 1'b0;
`endif

  always #5 clk = ~clk;

  nibble_serial_alu_ctrl #(.NIBBLES(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .a_in        (a_in),
    .b_in        (b_in),
    .s_in        (s_in),
    .cin_in      (cin_in),
    .au_a        (au_a),
    .au_b        (au_b),
    .au_s        (au_s),
    .au_cin      (au_cin),
    .au_r        (au_r),
    .au_cout     (au_cout),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .result      (result),
    .cout        (cout),
    .zero        (zero),
    .ovf         (ovf)
  );

  // Behavioural stand-in for the 4-bit arithmetic unit
  logic [3:0] au_d;
  logic [4:0] au_sum;
  always_comb begin
    case (au_s)
      2'b00:   au_d = au_b;
      2'b01:   au_d = ~au_b;
      2'b10:   au_d = 4'h0;
      default: au_d = 4'hF;
    endcase
    au_sum = {1'b0, au_a} + {1'b0, au_d} + {4'b0, au_cin};
  end
  assign au_r    = au_sum[3:0];
  assign au_cout = au_sum[4];

  typedef struct {
    string       name;
    logic [15:0] a;
    logic [15:0] b;
    logic [1:0]  s;
    logic        cin;
    logic [15:0] res;
    logic        co;
    logic        z;
    logic        ov;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic [1:0] s, input logic cin, input string nm);
    @(negedge clk);
    a_in = a; b_in = b; s_in = s; cin_in = cin; start_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_valid = 1'b0;
    chk({nm, " au_a first"}, 32'(au_a), 32'(a[3:0]));
    chk({nm, " au_b first"}, 32'(au_b), 32'(b[3:0]));
    chk({nm, " au_s"}, 32'(au_s), 32'(s));
    chk({nm, " au_cin first"}, 32'(au_cin), 32'(cin));
    chk({nm, " start_ready busy"}, 32'(start_ready), 32'd0);
  endtask

  task automatic wait_valid(input string nm);
    int n;
    n = 0;
    while (!res_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({nm, " latency"}, 32'(n), 32'd4);
  endtask

  task automatic consume(input string nm);
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    chk({nm, " start_ready after take"}, 32'(start_ready), 32'd1);
    chk({nm, " res_valid after take"}, 32'(res_valid), 32'd0);
  endtask

  task automatic run_vec(input vec_t v);
    issue(v.a, v.b, v.s, v.cin, v.name);
    wait_valid(v.name);
    chk({v.name, " result"}, 32'(result), 32'(v.res));
    chk({v.name, " cout"}, 32'(cout), 32'(v.co));
    chk({v.name, " zero"}, 32'(zero), 32'(v.z & FLAGS_ON));
    chk({v.name, " ovf"}, 32'(ovf), 32'(v.ov & FLAGS_ON));
    consume(v.name);
  endtask

  initial begin
    vecs[0] = '{"add_1234_0fff", 16'h1234, 16'h0FFF, 2'b00, 1'b0, 16'h2233, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{"sub_5_7",       16'h0005, 16'h0007, 2'b01, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{"add_ovf",       16'h7FFF, 16'h0001, 2'b00, 1'b0, 16'h8000, 1'b0, 1'b0, 1'b1};
    vecs[3] = '{"inc_ffff",      16'hFFFF, 16'h0000, 2'b10, 1'b1, 16'h0000, 1'b1, 1'b1, 1'b0};
    vecs[4] = '{"dec_0",         16'h0000, 16'h1234, 2'b11, 1'b0, 16'hFFFF, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{"sub_equal",     16'h4321, 16'h4321, 2'b01, 1'b1, 16'h0000, 1'b1, 1'b1, 1'b0};
    vecs[6] = '{"sub_neg_ovf",   16'h8000, 16'h0001, 2'b01, 1'b1, 16'h7FFF, 1'b1, 1'b0, 1'b1};

    rst_n = 1'b0; start_valid = 1'b0; res_ready = 1'b0;
    a_in = '0; b_in = '0; s_in = '0; cin_in = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset start_ready", 32'(start_ready), 32'd1);
    chk("reset res_valid", 32'(res_valid), 32'd0);
    chk("reset result", 32'(result), 32'd0);
    chk("reset au_a", 32'(au_a), 32'd0);
    chk("reset au_cin", 32'(au_cin), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // res_ready high outside DONE must be ignored
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    chk("idle res_ready ignored", 32'(start_ready), 32'd1);

    for (int i = 0; i < 7; i++) run_vec(vecs[i]);

    // Stall in DONE with stray start requests
    issue(16'h0001, 16'h0001, 2'b00, 1'b0, "stall");
    wait_valid("stall");
    for (int i = 0; i < 3; i++) begin
      start_valid = 1'b1;
      a_in = 16'hAAAA;
      @(negedge clk);
      chk("stall result stable", 32'(result), 32'h0002);
      chk("stall res_valid", 32'(res_valid), 32'd1);
      chk("stall start_ready", 32'(start_ready), 32'd0);
    end
    start_valid = 1'b0;
    consume("stall");
    @(negedge clk);
    chk("stall no queued op", 32'(start_ready), 32'd1);

    // Reset during the second RUN cycle
    issue(16'h1111, 16'h2222, 2'b00, 1'b0, "abort");
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort start_ready", 32'(start_ready), 32'd1);
    chk("abort res_valid", 32'(res_valid), 32'd0);
    chk("abort result", 32'(result), 32'd0);
    chk("abort cout", 32'(cout), 32'd0);
    chk("abort zero", 32'(zero), 32'd0);
    chk("abort ovf", 32'(ovf), 32'd0);
    chk("abort au_a", 32'(au_a), 32'd0);
    chk("abort au_b", 32'(au_b), 32'd0);
    chk("abort au_s", 32'(au_s), 32'd0);
    chk("abort au_cin", 32'(au_cin), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_vec('{"post_reset", 16'h00FF, 16'h0001, 2'b00, 1'b0, 16'h0100, 1'b0, 1'b0, 1'b0});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/nibble_serial_alu_ctrl.md
# nibble_serial_alu_ctrl

Multi-cycle sequencer that runs wide (4×NIBBLES-bit) add/subtract operations through the existing 4-bit `arthmetic_unit`, one nibble per clock, LSB nibble first. It sits directly upstream of that unit, driving its A/B/S/C_in, and also consumes its R/C_out. It accepts operands over a valid/ready handshake and returns the registered wide result with carry and flags over a second valid/ready handshake.

## Interface
- NIBBLES, 4, number of nibbles per operation; W = 4*NIBBLES; minimum 2
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start_valid  in  1  operation request
- start_ready  out  1  block can accept a request (high only in IDLE)
- a_in, b_in  in  W  operands, sampled on accept
- s_in  in  2  operand select for the unit: 00 B, 01 ~B, 10 0, 11 all-ones
- cin_in  in  1  initial carry, sampled on accept
- au_a, au_b  out  4  current nibble to the arithmetic unit
- au_s  out  2  latched s_in
- au_cin  out  1  running carry
- au_r  in  4  unit sum, combinational, same cycle
- au_cout  in  1  unit carry-out, same cycle
- res_valid  out  1  result available
- res_ready  in  1  consumer takes result
- result  out  W  wide result
- cout  out  1  final carry-out
- zero, ovf  out  1  result==0; signed overflow

## Operation
- FSM: IDLE, RUN, DONE (2-bit encoding).
- IDLE: start_ready=1; au_* driven 0. On start_valid: latch a_in/b_in into shift registers, s_in into s_reg, cin_in into carry_reg, cnt=0 → RUN.
- RUN: au_a=a_sh[3:0], au_b=b_sh[3:0], au_s=s_reg, au_cin=carry_reg. Each edge: shift a_sh/b_sh right 4; shift au_r into result from the top (res_sh = {au_r, res_sh[W-1:4]}); carry_reg<=au_cout; cnt++. When cnt==NIBBLES-1: also latch cout<=au_cout and flags → DONE.
- Signed overflow on last nibble: d3 = b_sh[3] for s=00, ~b_sh[3] for 01, 0 for 10, 1 for 11; ovf = (a_sh[3]==d3) && (au_r[3]!=a_sh[3]).
- zero = ({au_r, res_sh[W-1:4] shifted value} == 0) evaluated on the final edge.
- DONE: res_valid=1; result/cout/zero/ovf held stable. On res_ready → IDLE. start_ready=0 in RUN and DONE (no overlap).
- s/cin semantics: A+B (00,0), A-B (01,1), A+1 (10,1), A-1 (11,0).

## Timing
- Reset (async assert, sync-free release): state IDLE, start_ready=1, res_valid=0, result=0, cout=0, zero=0, ovf=0, au_a=au_b=0, au_s=0, au_cin=0, carry_reg=0, cnt=0.
- Accept at edge E0 → nibble k computed in cycle after E0+k, latched at E0+k+1.
- res_valid rises after edge E0+NIBBLES: latency NIBBLES cycles accept-to-valid.
- Result consumed at edge where res_valid&&res_ready; start_ready high the following cycle; minimum issue interval NIBBLES+2 cycles.
- res_ready held low: DONE indefinitely, outputs stable.
- res_ready high while not in DONE: ignored.
- start_valid outside IDLE: ignored, not queued.
- rst_n low in any state: operation discarded, all outputs to reset values immediately.
- Carry out of nibble k feeds nibble k+1 only through carry_reg (no combinational loop through au_cin).

## Configuration
- NSALU_FLAGS_EN defined: zero and ovf computed and registered as above.
- Undefined: zero and ovf tied 0, d3/flag logic absent; result, cout, handshakes, latency unchanged.

## Structure
- Shared defines header `alu_defs.vh`: s encodings (AU_S_B, AU_S_NB, AU_S_ZERO, AU_S_ONES), FSM state encodings, NIBBLE_W=4.
- One sub-module: `nibble_shreg` (parameterised W, load/shift-by-4 right, serial 4-bit in at top, LSB nibble out), instantiated three times (a, b, result).
- `arthmetic_unit` is instantiated by the parent, not inside this block.

## Test plan (NIBBLES=4, bench instantiates `arthmetic_unit` on au_* ports)
- 0x1234 + 0x0FFF, s=00 cin=0 → result 0x2233, cout 0, ovf 0, res_valid exactly 4 cycles after accept.
- 0x0005 − 0x0007, s=01 cin=1 → 0xFFFE, cout 0, zero 0, ovf 0.
- 0x7FFF + 0x0001, s=00 cin=0 → 0x8000, ovf 1, cout 0; flags 0 when macro undefined.
- 0xFFFF, s=10 cin=1 → 0x0000, cout 1, zero 1, ovf 0.
- res_ready low 3 cycles in DONE → result stable, start_ready 0, start_valid pulses ignored; res_ready high → start_ready 1 next cycle.
- rst_n pulsed low during 2nd RUN cycle → all outputs at reset values immediately; next op 0x00FF + 0x0001 → 0x0100 correct.
